obc_shift_accumulator: RTL and testbench

Bit-serial controller and shift-accumulator for the OBC distributed-arithmetic DFT datapath. It sits downstream of the ROM combine stage, which delivers the sign-corrected sum of eight OBC ROM lookups for one bit-slice per cycle. This block sequences the bit-slices MSB-first and drives the slice index and MSB-slice flag `msb_o`, which feeds the ROM stage's `m` input. It shift-accumulates the returned slice sums, adds the OBC offset term, halves the result, and presents one DFT output coefficient on a valid/ready handshake.

---
 rtl/obc_pkg.sv | 24 ++
 rtl/obc_shift_accumulator.sv | 144 ++++++++++++++
 tb/tb_obc_shift_accumulator.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/obc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : obc_pkg
// Description : Shared types and default sizing for the OBC distributed-
//               arithmetic shift-accumulator.
//               - obc_acc_state_t : controller state encoding
//               - OBC_B           : default bit-slices per result
//               - OBC_ROM_W       : default ROM-stage slice-sum width
// Revision    : 1.0  initial release
// ============================================================================
package obc_pkg;

   localparam int OBC_B     = 16;
   localparam int OBC_ROM_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_FIN  = 2'd2,
      ST_HOLD = 2'd3
   } obc_acc_state_t;

endpackage
`default_nettype wire

// File: rtl/obc_shift_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : obc_shift_accumulator
// Description : Bit-serial controller and shift-accumulator for the OBC DA
//               DFT datapath. Walks the bit-slices MSB-first, accumulates
//               the ROM-stage slice sums, adds the OBC offset, halves the
//               total (floor) and presents the coefficient on valid/ready.
// Ports       : clk, rst_n      clock, synchronous active-low reset
//               start_i         request a new accumulation
//               offset_i        signed OBC offset, captured on start accept
//               bit_idx_o       slice index to serializer / ROM stage
//               msb_o           MSB-slice flag, drives ROM stage m input
//               rom_i           signed slice sum for bit_idx_o (same cycle)
//               busy_o          accumulation or finalisation in progress
//               y_o, y_valid_o  registered result and its valid flag
//               y_ready_i       consumer accepts result
// Revision    : 1.0  initial release
// ============================================================================
module obc_shift_accumulator
   import obc_pkg::*;
#(
   parameter int B     = OBC_B,
   parameter int ROM_W = OBC_ROM_W,
   parameter int ACC_W = ROM_W + B,
   parameter int IDX_W = $clog2(B)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [ACC_W-1:0] offset_i,
   output logic [IDX_W-1:0] bit_idx_o,
   output logic             msb_o,
   input  logic [ROM_W-1:0] rom_i,
   output logic             busy_o,
   output logic [ACC_W-1:0] y_o,
   output logic             y_valid_o,
   input  logic             y_ready_i
);

   localparam logic [IDX_W-1:0] c_idx_max = IDX_W'(B - 1);

   obc_acc_state_t r_state;
   obc_acc_state_t w_state_next;
   logic           w_accept;

   logic [IDX_W-1:0]        r_idx;
   logic signed [ACC_W-1:0] r_acc;
   logic signed [ACC_W-1:0] r_offset;
   logic [ACC_W-1:0]        r_y;
   logic                    r_y_valid;

   logic signed [ACC_W-1:0] w_rom_ext;
   logic signed [ACC_W-1:0] w_acc_next;
   logic signed [ACC_W-1:0] w_sum;
   logic signed [ACC_W-1:0] w_y_next;

   // Slice sums are weighted by the remaining slices through the left
   // shift; the MSB slice already carries its negative weight from the
   // ROM stage (via msb_o), so no correction is applied here.
   assign w_rom_ext  = ACC_W'($signed(rom_i));
   assign w_acc_next = (r_acc <<< 1) + w_rom_ext;
   assign w_sum      = r_acc + r_offset;
   assign w_y_next   = w_sum >>> 1;   // arithmetic: floors toward -inf

   // ------------------------------------------------------------------
   // Next-state logic. A start is only honoured in IDLE, or in HOLD on
   // the same edge the pending result is handed off.
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start_i) begin
               w_accept     = 1'b1;
               w_state_next = ST_ACC;
            end
         end
         ST_ACC: begin
            if (r_idx == '0) begin
               w_state_next = ST_FIN;
            end
         end
         ST_FIN: begin
            w_state_next = ST_HOLD;
         end
         ST_HOLD: begin
            if (y_ready_i) begin
               if (start_i) begin
                  w_accept     = 1'b1;
                  w_state_next = ST_ACC;
               end else begin
                  w_state_next = ST_IDLE;
               end
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_idx     <= '0;
         r_acc     <= '0;
         r_offset  <= '0;
         r_y       <= '0;
         r_y_valid <= 1'b0;
      end else begin
         r_state <= w_state_next;

         if (w_accept) begin
            r_offset <= offset_i;
            r_acc    <= '0;
            r_idx    <= c_idx_max;
         end else if (r_state == ST_ACC) begin
            r_acc <= w_acc_next;
            if (r_idx != '0) begin
               r_idx <= r_idx - IDX_W'(1);
            end
         end

         if (r_state == ST_FIN) begin
            r_y       <= w_y_next;
            r_y_valid <= 1'b1;
         end else if ((r_state == ST_HOLD) && y_ready_i) begin
            r_y_valid <= 1'b0;
         end
      end
   end

   assign bit_idx_o = (r_state == ST_ACC) ? r_idx : '0;
   assign msb_o     = (r_state == ST_ACC) && (r_idx == c_idx_max);
   assign busy_o    = (r_state == ST_ACC) || (r_state == ST_FIN);
   assign y_o       = r_y;
   assign y_valid_o = r_y_valid;

endmodule
`default_nettype wire

// File: tb/tb_obc_shift_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_obc_shift_accumulator
// Description : Directed self-checking bench for obc_shift_accumulator.
//               A small slice table answers the DUT's bit_idx_o with the
//               slice sum for that index; expected results are hand-worked.
// Revision    : 1.0  initial release
// ============================================================================
module tb_obc_shift_accumulator;

   localparam int B     = 16;
   localparam int ROM_W = 32;
   localparam int ACC_W = ROM_W + B;
   localparam int IDX_W = $clog2(B);

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start_i;
   logic [ACC_W-1:0] offset_i;
   logic [IDX_W-1:0] bit_idx_o;
   logic             msb_o;
   logic [ROM_W-1:0] rom_i;
   logic             busy_o;
   logic [ACC_W-1:0] y_o;
   logic             y_valid_o;
   logic             y_ready_i;

   logic [ROM_W-1:0] rom_tab [B];

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   // ROM stage stand-in: combinational answer for the addressed slice
   always_comb rom_i = rom_tab[bit_idx_o];

   obc_shift_accumulator #(
      .B     (B),
      .ROM_W (ROM_W),
      .ACC_W (ACC_W),
      .IDX_W (IDX_W)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (start_i),
      .offset_i  (offset_i),
      .bit_idx_o (bit_idx_o),
      .msb_o     (msb_o),
      .rom_i     (rom_i),
      .busy_o    (busy_o),
      .y_o       (y_o),
      .y_valid_o (y_valid_o),
      .y_ready_i (y_ready_i)
   );

   task automatic check_val(input string tag, input logic [ACC_W-1:0] got,
                            input logic [ACC_W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_tab(input int msb_val, input int rest_val);
      for (int i = 0; i < B; i++) rom_tab[i] = ROM_W'(rest_val);
      rom_tab[B-1] = ROM_W'(msb_val);
   endtask

   task automatic start_op(input int off);
      offset_i = ACC_W'(off);
      start_i  = 1'b1;
      tick();
      start_i  = 1'b0;
   endtask

   // Called just after the accepting edge. Edges are counted with the
   // accepting edge as 1, so valid is expected at count B+2.
   // poke_n > 0 raises start_i (with a bogus offset) at that ACC cycle.
   task automatic finish_op(input string tag, input int exp_y, input int poke_n);
      int n       = 1;
      int seq_err = 0;
      while (!y_valid_o && n < 100) begin
         start_i = (n == poke_n);
         if (n == poke_n) offset_i = ACC_W'(100);
         if (n <= B) begin
            if (bit_idx_o !== IDX_W'(B - n)) seq_err++;
            if (msb_o !== (n == 1))           seq_err++;
            if (busy_o !== 1'b1)              seq_err++;
         end
         tick();
         n++;
      end
      start_i = 1'b0;
      check_val({tag, " latency"},  ACC_W'(n), ACC_W'(B + 2));
      check_val({tag, " idx/msb"},  ACC_W'(seq_err), '0);
      check_val({tag, " y"},        y_o, ACC_W'(exp_y));
   endtask

   task automatic ack_op(input string tag);
      y_ready_i = 1'b1;
      tick();
      check_val({tag, " valid drop"}, ACC_W'(y_valid_o), '0);
   endtask

   initial begin
      int stray;
      int hold_err;
      logic [ACC_W-1:0] held_y;

      rst_n     = 1'b0;
      start_i   = 1'b1;
      offset_i  = '0;
      y_ready_i = 1'b1;
      fill_tab(0, 0);

      // Reset dominates a held start
      repeat (3) tick();
      check_val("rst y",       y_o, '0);
      check_val("rst valid",   ACC_W'(y_valid_o), '0);
      check_val("rst busy",    ACC_W'(busy_o), '0);
      check_val("rst msb",     ACC_W'(msb_o), '0);
      check_val("rst bit_idx", ACC_W'(bit_idx_o), '0);

      rst_n   = 1'b1;
      start_i = 1'b0;
      repeat (5) tick();
      check_val("idle busy", ACC_W'(busy_o), '0);

      // All slices +1: acc = 2^16-1
      fill_tab(1, 1);
      start_op(0);
      finish_op("ones off0", 32767, 0);
      ack_op("ones off0");

      start_op(1);
      finish_op("ones off1", 32768, 0);
      ack_op("ones off1");

      // All slices -1: acc = -65535, halved with floor
      fill_tab(-1, -1);
      start_op(0);
      finish_op("neg ones", -32768, 0);
      ack_op("neg ones");

      // Only MSB slice: -5 * 2^15 / 2
      fill_tab(-5, 0);
      start_op(0);
      finish_op("msb only", -81920, 0);
      ack_op("msb only");

      // Backpressure: result held, start during HOLD ignored
      fill_tab(1, 1);
      y_ready_i = 1'b0;
      start_op(0);
      finish_op("bp", 32767, 0);
      held_y   = y_o;
      hold_err = 0;
      for (int i = 0; i < 10; i++) begin
         start_i  = (i == 3);
         offset_i = ACC_W'(5);
         tick();
         if (y_o !== held_y || y_valid_o !== 1'b1 || busy_o !== 1'b0) hold_err++;
      end
      check_val("bp hold stable", ACC_W'(hold_err), '0);
      y_ready_i = 1'b1;
      start_i   = 1'b1;
      offset_i  = ACC_W'(1);
      tick();
      start_i   = 1'b0;
      check_val("bp restart busy",  ACC_W'(busy_o), ACC_W'(1));
      check_val("bp restart idx",   ACC_W'(bit_idx_o), ACC_W'(15));
      check_val("bp restart valid", ACC_W'(y_valid_o), '0);
      finish_op("bp next", 32768, 0);
      ack_op("bp next");

      // Start during ACC is ignored; original offset kept, no second result
      start_op(0);
      finish_op("ign start", 32767, 5);
      ack_op("ign start");
      stray = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (y_valid_o || busy_o) stray++;
      end
      check_val("ign start no queue", ACC_W'(stray), '0);

      // Reset mid-accumulation; y_o currently nonzero from previous run
      start_op(1);
      for (int i = 0; i < 20 && bit_idx_o != IDX_W'(7); i++) tick();
      check_val("mid rst reached idx7", ACC_W'(bit_idx_o), ACC_W'(7));
      rst_n = 1'b0;
      tick();
      check_val("mid rst y",     y_o, '0);
      check_val("mid rst valid", ACC_W'(y_valid_o), '0);
      check_val("mid rst busy",  ACC_W'(busy_o), '0);
      check_val("mid rst msb",   ACC_W'(msb_o), '0);
      check_val("mid rst idx",   ACC_W'(bit_idx_o), '0);
      rst_n = 1'b1;
      tick();
      check_val("post rst idle", ACC_W'(busy_o), '0);
      start_op(0);
      finish_op("post rst", 32767, 0);
      ack_op("post rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
